cond_unit: RTL

Condition-check and flags-register block for the CPU datapath. It consumes the 4-bit `{N,Z,C,V}` flags produced by `alu` and holds them in an architectural flags register. It evaluates the 4-bit condition field of each instruction against the stored flags. It gates the decoder's register-write, memory-write and PC-select strobes so that an instruction only takes effect when its condition passes.

---
 rtl/cond_unit.sv | 100 ++++++++++
 1 files changed

// File: rtl/cond_unit.sv
`default_nettype none
// ============================================================================
// Module      : cond_unit
// Description : Architectural {N,Z,C,V} flags register and condition check.
//               Gates the decoder write/PC strobes with the condition result.
// Revision    : 1.0 - initial release
// ============================================================================
module cond_unit (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] cond,
    input  logic [3:0] alu_flags,
    input  logic [1:0] flag_w,
    input  logic       reg_write,
    input  logic       mem_write,
    input  logic       pc_src,
    output logic       cond_ex,
    output logic       reg_write_o,
    output logic       mem_write_o,
    output logic       pc_src_o,
    output logic [3:0] flags
);

    localparam logic [3:0] c_EQ = 4'b0000;
    localparam logic [3:0] c_NE = 4'b0001;
    localparam logic [3:0] c_CS = 4'b0010;
    localparam logic [3:0] c_CC = 4'b0011;
    localparam logic [3:0] c_MI = 4'b0100;
    localparam logic [3:0] c_PL = 4'b0101;
    localparam logic [3:0] c_VS = 4'b0110;
    localparam logic [3:0] c_VC = 4'b0111;
    localparam logic [3:0] c_HI = 4'b1000;
    localparam logic [3:0] c_LS = 4'b1001;
    localparam logic [3:0] c_GE = 4'b1010;
    localparam logic [3:0] c_LT = 4'b1011;
    localparam logic [3:0] c_GT = 4'b1100;
    localparam logic [3:0] c_LE = 4'b1101;
    localparam logic [3:0] c_AL = 4'b1110;

    logic [3:0] r_flags;
    logic       w_n;
    logic       w_z;
    logic       w_c;
    logic       w_v;
    logic       w_cond_ex;
    logic       w_commit;

    assign w_n = r_flags[3];
    assign w_z = r_flags[2];
    assign w_c = r_flags[1];
    assign w_v = r_flags[0];

    // Evaluated against the registered flags only, so an instruction never
    // sees its own flag result.
    always_comb begin
        w_cond_ex = 1'b0;
        case (cond)
            c_EQ:    w_cond_ex = w_z;
            c_NE:    w_cond_ex = !w_z;
            c_CS:    w_cond_ex = w_c;
            c_CC:    w_cond_ex = !w_c;
            c_MI:    w_cond_ex = w_n;
            c_PL:    w_cond_ex = !w_n;
            c_VS:    w_cond_ex = w_v;
            c_VC:    w_cond_ex = !w_v;
            c_HI:    w_cond_ex = w_c && !w_z;
            c_LS:    w_cond_ex = !w_c || w_z;
            c_GE:    w_cond_ex = (w_n == w_v);
            c_LT:    w_cond_ex = (w_n != w_v);
            c_GT:    w_cond_ex = !w_z && (w_n == w_v);
            c_LE:    w_cond_ex = w_z || (w_n != w_v);
            c_AL:    w_cond_ex = 1'b1;
            default: w_cond_ex = 1'b0;
        endcase
    end

    assign w_commit = en && w_cond_ex;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_flags <= 4'b0000;
        end else if (w_commit) begin
            if (flag_w[1]) begin
                r_flags[3:2] <= alu_flags[3:2];
            end
            if (flag_w[0]) begin
                r_flags[1:0] <= alu_flags[1:0];
            end
        end
    end

    assign cond_ex     = w_cond_ex;
    assign reg_write_o = reg_write && w_commit;
    assign mem_write_o = mem_write && w_commit;
    assign pc_src_o    = pc_src    && w_commit;
    assign flags       = r_flags;

endmodule
`default_nettype wire
